// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types for the peripheral memory bus initiator (FSM states, command record, data width)
package mem_bus_pkg;

   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   typedef struct packed {
      logic                  we;
      logic [31:0]           addr;
      logic [MEM_DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/mem_cmd_fifo.sv
// mem_cmd_fifo: synchronous FIFO of bus commands, head visible combinationally
module mem_cmd_fifo
   import mem_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_push,
   input  cmd_t i_data,
   input  logic i_pop,
   output logic o_full,
   output logic o_empty,
   output cmd_t o_head
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [AW:0] r_wr;
   logic [AW:0] r_rd;
   cmd_t        r_mem [FIFO_DEPTH];
   logic        w_push;
   logic        w_pop;

   assign o_empty = r_wr == r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd[AW-1:0]];

   // Pointers carry one extra bit so equal indices distinguish full from empty
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
      end

   // Storage needs no reset: entries are only read after being written
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: valid/ready bus master, one outstanding transaction; optional timeout via MEM_INITIATOR_TIMEOUT_EN
module mem_initiator
   import mem_bus_pkg::*;
#(
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [31:0]           cmd_addr,
   input  logic [MEM_DATA_W-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [MEM_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic                  mem_we,
   output logic [31:0]           mem_addr,
   output logic [MEM_DATA_W-1:0] mem_wdata,
   input  logic [MEM_DATA_W-1:0] mem_rdata
);

   state_t r_state;
   cmd_t   w_head;
   logic   w_full;
   logic   w_empty;
   logic   w_pop;

   // A new transaction starts from IDLE, or straight from RESP as the response drains,
   // which keeps one idle bus cycle between transactions while sustaining 3 cycles each
   assign w_pop     = !w_empty && (r_state == IDLE || (r_state == RESP && rsp_ready));
   assign cmd_ready = !w_full;

   mem_cmd_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .i_push (cmd_valid),
      .i_data ({cmd_we, cmd_addr, cmd_wdata}),
      .i_pop  (w_pop),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_head (w_head)
   );

`ifdef MEM_INITIATOR_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] r_cnt;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = TIMEOUT_CYCLES != 0;
`endif

   // Transaction FSM: issue from FIFO head, wait for ready (or timeout), hold response until taken
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         r_state   <= IDLE;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: ;
            ISSUE:
               if (mem_ready) begin
                  rsp_rdata <= mem_we ? '0 : mem_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  r_state   <= RESP;
               end
`ifdef MEM_INITIATOR_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  mem_valid <= 1'b0;
                  mem_we    <= 1'b0;
                  r_state   <= RESP;
               end else
                  r_cnt <= r_cnt + CW'(1);
`endif
            RESP:
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  r_state   <= IDLE;
               end
            default: r_state <= IDLE;
         endcase
         if (w_pop) begin
            mem_valid <= 1'b1;
            mem_we    <= w_head.we;
            mem_addr  <= w_head.addr;
            mem_wdata <= w_head.wdata;
            r_state   <= ISSUE;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            r_cnt     <= '0;
`endif
         end
      end

endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized bench with a word-memory responder and an in-order reference model
module tb_mem_initiator;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mem_initiator #(
      .FIFO_DEPTH(2),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Responder: 16-word memory, ready registered from valid.
   // mode 0 = normal, 1 = ready lingers one cycle after completion, 2 = never ready
   int          mode = 0;
   logic        rdy;
   logic        hold;
   logic [31:0] rmem [16];

   always @(posedge clk or negedge resetn)
      if (!resetn) begin
         rdy  <= 1'b0;
         hold <= 1'b0;
      end else begin
         if (mem_valid && rdy && mem_we) rmem[mem_addr[5:2]] <= mem_wdata;
         if (mode == 2) rdy <= 1'b0;
         else if (mem_valid && !rdy) begin
            rdy  <= 1'b1;
            hold <= (mode == 1);
         end else if (rdy && hold) hold <= 1'b0;
         else rdy <= 1'b0;
      end

   assign mem_ready = rdy;
   assign mem_rdata = rdy ? rmem[mem_addr[5:2]] : 32'hDEAD_BEEF;

   // Reference model: commands applied in acceptance order to a plain word array
   logic [31:0] ref_mem [16];
   logic [32:0] exp_q[$];
   logic [32:0] act_q[$];

   // Protocol monitor and response collector
   int          n_done = 0;
   int          n_rsp = 0;
   int          viol = 0;
   logic        done_d = 1'b0;
   logic        v_nd = 1'b0;
   logic        r_nd = 1'b0;
   logic [64:0] bus_d;
   logic [32:0] rsp_d;

   always @(posedge clk) begin
      if (resetn) begin
         if (done_d && mem_valid) viol <= viol + 1;
         if (mem_we && !mem_valid) viol <= viol + 1;
         if (v_nd && mem_valid && {mem_we, mem_addr, mem_wdata} != bus_d) viol <= viol + 1;
         if (r_nd && (!rsp_valid || {rsp_err, rsp_rdata} != rsp_d)) viol <= viol + 1;
         if (mem_valid && mem_ready) n_done <= n_done + 1;
         if (rsp_valid && rsp_ready) begin
            act_q.push_back({rsp_err, rsp_rdata});
            n_rsp <= n_rsp + 1;
         end
      end
      done_d <= resetn && mem_valid && mem_ready;
      v_nd   <= resetn && mem_valid && !mem_ready;
      r_nd   <= resetn && rsp_valid && !rsp_ready;
      bus_d  <= {mem_we, mem_addr, mem_wdata};
      rsp_d  <= {rsp_err, rsp_rdata};
   end

   task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_wdata = d;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 200) $display("FAIL push_accept: cmd_ready stuck low for %0d cycles, required acceptance", n);
      else passed++;
      @(negedge clk);
      cmd_valid = 1'b0;
      if (we) begin
         ref_mem[a[5:2]] = d;
         exp_q.push_back({1'b0, 32'h0});
      end else exp_q.push_back({1'b0, ref_mem[a[5:2]]});
   endtask

   function automatic logic [31:0] rnd_addr();
      logic [3:0] w = 4'($urandom_range(0, 15));
      return {26'h0, w, 2'b00};
   endfunction

   task automatic drain(input string name);
      int n = 0;
      while (act_q.size() < exp_q.size() && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      checks++;
      if (act_q.size() != exp_q.size())
         $display("FAIL %s_count: got %0d responses, required %0d", name, act_q.size(), exp_q.size());
      else passed++;
      while (act_q.size() > 0 && exp_q.size() > 0) begin
         logic [32:0] a = act_q.pop_front();
         logic [32:0] e = exp_q.pop_front();
         checks++;
         if (a !== e) $display("FAIL %s_rsp: got err=%b rdata=%h, required err=%b rdata=%h", name, a[32], a[31:0], e[32], e[31:0]);
         else passed++;
      end
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata} !== '0)
         $display("FAIL reset_outputs: got rsp_v=%b err=%b rdata=%h mem_v=%b we=%b addr=%h wdata=%h, required all 0",
                  rsp_valid, rsp_err, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata);
      else passed++;
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b, required 1", cmd_ready);
      else passed++;
   endtask

   task automatic test_write_read();
      int k = 0;
      int first_v = 0;
      int gaps = viol;
      mode = 0;
      rsp_ready = 1'b1;
      push(1'b1, 32'h04, 32'h5);
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
         if (mem_valid && first_v == 0) first_v = k;
      end
      checks++;
      if (first_v != 1) $display("FAIL wr_mem_valid_latency: got %0d cycles, required 1", first_v);
      else passed++;
      checks++;
      if (k != 3) $display("FAIL wr_rsp_latency: got %0d cycles, required 3", k);
      else passed++;
      push(1'b0, 32'h04, 32'h0);
      k = 0;
      while (act_q.size() < 2 && k < 50) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (act_q.size() < 2 || act_q[0] !== 33'h0 || act_q[1] !== {1'b0, 32'h5})
         $display("FAIL wr_rd_values: got %0d responses (first %h second %h), required 000000000 then 000000005",
                  act_q.size(), act_q.size() > 0 ? act_q[0] : 33'h0, act_q.size() > 1 ? act_q[1] : 33'h0);
      else passed++;
      drain("write_read");
      checks++;
      if (viol != gaps) $display("FAIL wr_protocol: got %0d violations, required 0", viol - gaps);
      else passed++;
   endtask

   task automatic test_back_pressure();
      mode = 0;
      rsp_ready = 1'b0;
      push(1'b1, 32'h10, 32'hA5A5_0001);
      repeat (4) @(negedge clk);
      push(1'b0, 32'h10, 32'h0);
      push(1'b1, 32'h14, 32'h0000_BEEF);
      repeat (2) @(negedge clk);
      checks++;
      if ({cmd_ready, rsp_valid, mem_valid} !== 3'b010)
         $display("FAIL bp_full: got cmd_ready=%b rsp_valid=%b mem_valid=%b, required 0 1 0", cmd_ready, rsp_valid, mem_valid);
      else passed++;
      checks++;
      if (rsp_rdata !== 32'h0) $display("FAIL bp_parked_rdata: got %h, required 00000000", rsp_rdata);
      else passed++;
      rsp_ready = 1'b1;
      drain("back_pressure");
   endtask

   task automatic test_stale_ready();
      int d0 = n_done;
      int r0 = n_rsp;
      int v0 = viol;
      mode = 1;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) push(1'($urandom_range(0, 1)), rnd_addr(), $urandom);
      drain("stale_ready");
      checks++;
      if ((n_done - d0) != (n_rsp - r0))
         $display("FAIL stale_dup: got %0d bus completions vs %0d responses, required equal", n_done - d0, n_rsp - r0);
      else passed++;
      checks++;
      if (viol != v0) $display("FAIL stale_protocol: got %0d violations, required 0", viol - v0);
      else passed++;
   endtask

   task automatic test_random();
      int v0 = viol;
      bit stop = 0;
      mode = int'($urandom_range(0, 1));
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               push(1'($urandom_range(0, 1)), rnd_addr(), $urandom);
            end
            stop = 1;
         end
         begin
            while (!stop) begin
               rsp_ready = 1'($urandom_range(0, 1));
               @(negedge clk);
            end
         end
      join
      rsp_ready = 1'b1;
      drain("random");
      checks++;
      if (viol != v0) $display("FAIL random_protocol: got %0d violations, required 0", viol - v0);
      else passed++;
   endtask

   task automatic test_timeout();
      int hi = 0;
      int rv = 0;
      int r0 = n_rsp;
      mode = 2;
      rsp_ready = 1'b1;
      push(1'b0, 32'h08, 32'h0);
`ifdef MEM_INITIATOR_TIMEOUT_EN
      for (int k = 0; k < 100 && !rsp_valid; k++) begin
         @(negedge clk);
         if (mem_valid) hi++;
      end
      checks++;
      if (hi != 8) $display("FAIL timeout_valid_cycles: got %0d, required 8", hi);
      else passed++;
      void'(exp_q.pop_back());
      exp_q.push_back({1'b1, 32'h0});
      drain("timeout");
      mode = 0;
      push(1'b0, 32'h08, 32'h0);
      drain("after_timeout");
`else
      @(negedge clk);
      for (int k = 0; k < 1000; k++) begin
         if (mem_valid) hi++;
         if (rsp_valid) rv++;
         @(negedge clk);
      end
      checks++;
      if (hi != 1000) $display("FAIL no_timeout_valid: got %0d of 1000 cycles high, required 1000", hi);
      else passed++;
      checks++;
      if (rv != 0 || n_rsp != r0) $display("FAIL no_timeout_rsp: got %0d rsp_valid cycles, required 0", rv);
      else passed++;
`endif
   endtask

   task automatic test_reset_mid();
      int act = 0;
      mode = 2;
      rsp_ready = 1'b1;
      push(1'b0, rnd_addr(), 32'h0);
      push(1'b0, rnd_addr(), 32'h0);
      checks++;
      if (mem_valid !== 1'b1) $display("FAIL midreset_pre: got mem_valid=%b, required 1", mem_valid);
      else passed++;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({rsp_valid, rsp_err, rsp_rdata, mem_valid, mem_we, mem_addr, mem_wdata} !== '0 || cmd_ready !== 1'b1)
         $display("FAIL midreset_async: got mem_v=%b rsp_v=%b cmd_ready=%b addr=%h, required 0 0 1 00000000",
                  mem_valid, rsp_valid, cmd_ready, mem_addr);
      else passed++;
      @(negedge clk);
      resetn = 1'b1;
      exp_q.delete();
      act_q.delete();
      mode = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (mem_valid || rsp_valid) act++;
      end
      checks++;
      if (act != 0 || act_q.size() != 0) $display("FAIL midreset_quiet: got %0d active cycles, required 0", act);
      else passed++;
      push(1'b1, 32'h3C, 32'h1234_5678);
      push(1'b0, 32'h3C, 32'h0);
      drain("after_reset");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         rmem[i]    = $urandom;
         ref_mem[i] = rmem[i];
      end
      test_reset();
      test_write_read();
      test_back_pressure();
      test_stale_ready();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
